uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_transmitter_baud_gen.sv | 32 +++
 rtl/uart_transmitter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for transmitter and receiver: state encoding, frame widths, clog2.
// Define UART_TX_PARITY_EN to add the even-parity state to the transmitter frame.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_gen.sv
// Symbol timing for the UART transmitter: one-cycle symbol_edge every SYMBOL_EDGE_TIME cycles,
// realigned to the frame by restart.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int SYMBOL_EDGE_TIME = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic symbol_edge
);

  localparam int CW = clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // High during the final cycle of a symbol, so the FSM moves on at the next edge.
  assign symbol_edge = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, one start and one stop bit; valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output tx_state_t  state
);

  localparam int RAW_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int SYMBOL_EDGE_TIME = (RAW_EDGE_TIME < 2) ? 2 : RAW_EDGE_TIME;
  localparam int IW = clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  // Handshake: a byte transfers on a rising edge where data_in_valid and data_in_ready are both 1;
  // ready is a register that is high only in IDLE, so it never depends on valid in the same cycle.

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_q, bit_d, bit_nx;
  logic                 serial_d, ready_d;
  logic                 accept, symbol_edge;

  uart_baud_gen #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .restart    (accept),
    .symbol_edge(symbol_edge)
  );

  assign accept = (state_q == IDLE) && data_in_ready && data_in_valid;
  assign state  = state_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    bit_nx   = bit_q + IW'(1);
    serial_d = serial_out;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = data_in;
          bit_d    = '0;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (symbol_edge) begin
          state_d  = DATA;
          serial_d = shift_q[bit_q];
        end
      end
      DATA: begin
        if (symbol_edge) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = ^shift_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_nx;
            serial_d = shift_q[bit_nx];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (symbol_edge) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (symbol_edge) begin
          state_d  = IDLE;
          serial_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
    // Ready follows the state being entered, so it rises with the IDLE cycle between frames.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      serial_out    <= 1'b1;
      data_in_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      serial_out    <= serial_d;
      data_in_ready <= ready_d;
    end
  end

endmodule
